// File: rtl/aes128_sbox_arbiter_if.sv
// rtl/aes128_sbox_arbiter_if.sv - request/result bus of the two-requester shared S-box arbiter
interface aes128_sbox_arbiter_if;
    logic [1:0]      req_i;
    logic [1:0][3:0] len_i;
    logic [1:0][7:0] data_i;
    logic [1:0]      gnt_o;
    logic [3:0]      idx_o;
    logic [1:0]      valid_o;
    logic [7:0]      result_o;
    logic [1:0]      done_o;
    logic            busy_o;
    logic [7:0]      sbox_sub_o;
    logic [7:0]      sbox_sub_i;

    modport slave (
        input  req_i, len_i, data_i, sbox_sub_i,
        output gnt_o, idx_o, valid_o, result_o, done_o, busy_o, sbox_sub_o
    );

    modport master (
        output req_i, len_i, data_i, sbox_sub_i,
        input  gnt_o, idx_o, valid_o, result_o, done_o, busy_o, sbox_sub_o
    );
endinterface

// File: rtl/aes128_sbox_arbiter.sv
// rtl/aes128_sbox_arbiter.sv - round-robin burst arbiter sharing one S-box; AES128_SBOX_ARB_REG_EN registers the result
module aes128_sbox_arbiter #(
    parameter int MAX_BURST = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    aes128_sbox_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
`ifdef AES128_SBOX_ARB_REG_EN
    localparam logic [1:0] ST_DRAIN = 2'd2;
`endif
    localparam logic [3:0] LEN_CAP  = 4'(MAX_BURST - 1);

    logic [1:0] state;
    logic       owner;
    logic [3:0] len_q;
    logic [3:0] cnt;
    logic       ptr;
    logic [1:0] done_q;

    logic       pick;
    logic [3:0] pick_len;
    logic [1:0] owner_oh;
    logic       in_burst;
    logic       last_beat;

    // Contention goes to the pointer; a lone request wins outright.
    always_comb begin
        pick = 1'b0;
        if (bus.req_i == 2'b11) begin
            pick = ptr;
        end else if (bus.req_i[1]) begin
            pick = 1'b1;
        end
    end

    assign pick_len  = (bus.len_i[pick] > LEN_CAP) ? LEN_CAP : bus.len_i[pick];
    assign owner_oh  = owner ? 2'b10 : 2'b01;
    assign in_burst  = (state == ST_BURST);
    assign last_beat = in_burst && (cnt == len_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            owner  <= 1'b0;
            len_q  <= 4'd0;
            cnt    <= 4'd0;
            ptr    <= 1'b0;
            done_q <= 2'b00;
        end else begin
            done_q <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (|bus.req_i) begin
                        owner <= pick;
                        len_q <= pick_len;
                        cnt   <= 4'd0;
                        state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    // Hold the counter on the final beat so length 15 never wraps.
                    if (last_beat) begin
`ifdef AES128_SBOX_ARB_REG_EN
                        state  <= ST_DRAIN;
`else
                        state  <= ST_IDLE;
                        done_q <= owner_oh;
                        ptr    <= ~owner;
`endif
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
`ifdef AES128_SBOX_ARB_REG_EN
                ST_DRAIN: begin
                    state  <= ST_IDLE;
                    done_q <= owner_oh;
                    ptr    <= ~owner;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sbox_sub_o = in_burst ? bus.data_i[owner] : 8'd0;
    assign bus.done_o     = done_q;
    assign bus.busy_o     = (state != ST_IDLE);

`ifdef AES128_SBOX_ARB_REG_EN
    logic [7:0] res_q;
    logic [1:0] valid_q;
    logic [3:0] idx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q   <= 8'd0;
            valid_q <= 2'b00;
            idx_q   <= 4'd0;
        end else if (in_burst) begin
            res_q   <= bus.sbox_sub_i;
            valid_q <= owner_oh;
            idx_q   <= cnt;
        end else begin
            res_q   <= 8'd0;
            valid_q <= 2'b00;
            idx_q   <= 4'd0;
        end
    end

    // Grant stays up through DRAIN while the last registered result is emitted.
    assign bus.gnt_o    = (in_burst || (state == ST_DRAIN)) ? owner_oh : 2'b00;
    assign bus.result_o = res_q;
    assign bus.valid_o  = valid_q;
    assign bus.idx_o    = idx_q;
`else
    assign bus.gnt_o    = in_burst ? owner_oh : 2'b00;
    assign bus.result_o = in_burst ? bus.sbox_sub_i : 8'd0;
    assign bus.valid_o  = in_burst ? owner_oh : 2'b00;
    assign bus.idx_o    = in_burst ? cnt : 4'd0;
`endif
endmodule

// File: tb/tb_aes128_sbox_arbiter.sv
// tb/tb_aes128_sbox_arbiter.sv - directed bench for aes128_sbox_arbiter with an XOR-0x63 S-box model
module tb_aes128_sbox_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    aes128_sbox_arbiter_if bus ();

    assign bus.sbox_sub_i = bus.sbox_sub_o ^ 8'h63;
    assign bus.data_i[0]  = {4'h5, bus.idx_o};
    assign bus.data_i[1]  = {4'hC, bus.idx_o};

    aes128_sbox_arbiter dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'h0);
        chk({tag, "_gnt"}, 32'(bus.gnt_o), 32'h0);
        chk({tag, "_result"}, 32'(bus.result_o), 32'h0);
        chk({tag, "_idx"}, 32'(bus.idx_o), 32'h0);
        chk({tag, "_sbox"}, 32'(bus.sbox_sub_o), 32'h0);
    endtask

`ifndef AES128_SBOX_ARB_REG_EN
    task automatic run_burst(input int r, input int n, input int at,
                             input logic [1:0] req_new, input logic [3:0] len_new,
                             input string tag);
        logic [7:0] d;
        logic [1:0] oh;
        oh = (r == 1) ? 2'b10 : 2'b01;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = (r == 1) ? {4'hC, 4'(i)} : {4'h5, 4'(i)};
            chk($sformatf("%s_valid%0d", tag, i), 32'(bus.valid_o), 32'(oh));
            chk($sformatf("%s_gnt%0d", tag, i), 32'(bus.gnt_o), 32'(oh));
            chk($sformatf("%s_idx%0d", tag, i), 32'(bus.idx_o), 32'(i));
            chk($sformatf("%s_sbox%0d", tag, i), 32'(bus.sbox_sub_o), 32'(d));
            chk($sformatf("%s_result%0d", tag, i), 32'(bus.result_o), 32'(d ^ 8'h63));
            chk($sformatf("%s_done%0d", tag, i), 32'(bus.done_o), 32'h0);
            chk($sformatf("%s_busy%0d", tag, i), 32'(bus.busy_o), 32'h1);
            if (i == at) begin
                bus.req_i    = req_new;
                bus.len_i[r] = len_new;
            end
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        bus.req_i = 2'b00;
        bus.len_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy_o), 32'h0);
        chk("rst_done", 32'(bus.done_o), 32'h0);
        chk_quiet("rst");
        rst = 1'b0;

`ifndef AES128_SBOX_ARB_REG_EN
        // 16-byte burst on requester 0
        @(negedge clk);
        chk("t1_idle_busy", 32'(bus.busy_o), 32'h0);
        bus.req_i    = 2'b01;
        bus.len_i[0] = 4'd15;
        run_burst(0, 16, 0, 2'b00, 4'd15, "t1");
        @(negedge clk);
        chk("t1_done", 32'(bus.done_o), 32'h1);
        chk("t1_end_busy", 32'(bus.busy_o), 32'h0);
        chk_quiet("t1_end");
        @(negedge clk);
        chk("t1_done_clr", 32'(bus.done_o), 32'h0);
        chk("t1_idle2_busy", 32'(bus.busy_o), 32'h0);

        // Simultaneous requests right after reset: 0 first, then 1 after one bubble
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.req_i    = 2'b11;
        bus.len_i[0] = 4'd1;
        bus.len_i[1] = 4'd3;
        run_burst(0, 2, 0, 2'b11, 4'd1, "t2a");
        @(negedge clk);
        chk("t2_done0", 32'(bus.done_o), 32'h1);
        chk("t2_bubble_busy", 32'(bus.busy_o), 32'h0);
        chk("t2_bubble_valid", 32'(bus.valid_o), 32'h0);
        run_burst(1, 4, 0, 2'b00, 4'd3, "t2b");
        @(negedge clk);
        chk("t2_done1", 32'(bus.done_o), 32'h2);
        chk("t2_end_busy", 32'(bus.busy_o), 32'h0);

        // Drop req and change len mid-burst; latched length of 8 must hold
        bus.req_i    = 2'b01;
        bus.len_i[0] = 4'd7;
        run_burst(0, 8, 2, 2'b00, 4'd2, "t3");
        @(negedge clk);
        chk("t3_done", 32'(bus.done_o), 32'h1);
        chk("t3_end_valid", 32'(bus.valid_o), 32'h0);
        @(negedge clk);
        chk("t3_idle_busy", 32'(bus.busy_o), 32'h0);
        chk("t3_done_clr", 32'(bus.done_o), 32'h0);

        // Reset at idx 5 of a 16-byte burst, then serve a fresh 1-byte request
        bus.req_i    = 2'b01;
        bus.len_i[0] = 4'd15;
        run_burst(0, 6, 0, 2'b01, 4'd15, "t4");
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rst_busy", 32'(bus.busy_o), 32'h0);
        chk("t4_rst_done", 32'(bus.done_o), 32'h0);
        chk_quiet("t4_rst");
        rst          = 1'b0;
        bus.len_i[0] = 4'd0;
        @(negedge clk);
        chk("t4_new_valid", 32'(bus.valid_o), 32'h1);
        chk("t4_new_idx", 32'(bus.idx_o), 32'h0);
        chk("t4_new_result", 32'(bus.result_o), 32'h33);
        chk("t4_new_done", 32'(bus.done_o), 32'h0);
        bus.req_i = 2'b00;
        @(negedge clk);
        chk("t4_done", 32'(bus.done_o), 32'h1);
        chk("t4_end_valid", 32'(bus.valid_o), 32'h0);
        @(negedge clk);
        chk("t4_done_clr", 32'(bus.done_o), 32'h0);
        chk("t4_idle_busy", 32'(bus.busy_o), 32'h0);
`else
        // Registered result path: BURST, DRAIN, then done
        @(negedge clk);
        bus.req_i    = 2'b01;
        bus.len_i[0] = 4'd0;
        @(negedge clk);
        chk("r_burst_sbox", 32'(bus.sbox_sub_o), 32'h50);
        chk("r_burst_valid", 32'(bus.valid_o), 32'h0);
        chk("r_burst_gnt", 32'(bus.gnt_o), 32'h1);
        chk("r_burst_busy", 32'(bus.busy_o), 32'h1);
        bus.req_i = 2'b00;
        @(negedge clk);
        chk("r_drain_valid", 32'(bus.valid_o), 32'h1);
        chk("r_drain_result", 32'(bus.result_o), 32'h33);
        chk("r_drain_idx", 32'(bus.idx_o), 32'h0);
        chk("r_drain_gnt", 32'(bus.gnt_o), 32'h1);
        chk("r_drain_busy", 32'(bus.busy_o), 32'h1);
        chk("r_drain_sbox", 32'(bus.sbox_sub_o), 32'h0);
        chk("r_drain_done", 32'(bus.done_o), 32'h0);
        @(negedge clk);
        chk("r_done", 32'(bus.done_o), 32'h1);
        chk("r_end_busy", 32'(bus.busy_o), 32'h0);
        chk_quiet("r_end");
        @(negedge clk);
        chk("r_done_clr", 32'(bus.done_o), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aes128_sbox_arbiter.md
AES128_SBOX_ARBITER -- requirements
Module: aes128_sbox_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: MAX_BURST, default 16, maximum bytes per grant; len_i is 4 bits, so 16 is the ceiling.
REQ-003 clk_i  input  1  rising-edge clock.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 req_i  input  2  burst request; bit0 = sub-bytes datapath, bit1 = key-expansion.
REQ-006 len_i  input  2x4  per-requester burst length minus one (0 = 1 byte, 15 = 16 bytes).
REQ-007 data_i  input  2x8  per-requester plaintext byte for the current idx_o.
REQ-008 gnt_o  output  2  one-hot grant, held for the whole burst.
REQ-009 idx_o  output  4  byte index of the current result within the burst.
REQ-010 valid_o  output  2  one-hot per-requester result strobe.
REQ-011 result_o  output  8  substituted byte; only meaningful while a valid_o bit is high.
REQ-012 done_o  output  2  one-cycle completion pulse per requester.
REQ-013 busy_o  output  1  high while the FSM is not IDLE.
REQ-014 sbox_sub_o  output  8  byte sent to the shared combinational S-box.
REQ-015 sbox_sub_i  input  8  S-box result.

Function
REQ-016 FSM states: IDLE, BURST and, only when the macro is defined, DRAIN.
REQ-017 IDLE actions:
- Owner is the requester with req_i high; if both are high, owner is the round-robin pointer's choice.
- Latch owner and len_i[owner], clear the counter, go to BURST.
- No request: stay in IDLE.
REQ-018 The round-robin pointer SHALL reset to 0 and, on each burst completion, point to the non-owner.
REQ-019 BURST actions, each cycle:
- gnt_o[owner]=1, sbox_sub_o=data_i[owner], counter increments.
- When counter equals the latched length, leave BURST the next edge.
REQ-020 Latched length, owner and the running burst SHALL be unaffected by len_i changes or by req_i deasserting mid-burst.
REQ-021 Without the macro:
- In each BURST cycle: result_o=sbox_sub_i, valid_o[owner]=1, idx_o=counter.
- First valid is one cycle after req_i is sampled in IDLE.
REQ-022 done_o[owner] SHALL pulse exactly one cycle, in the cycle after the last valid.
REQ-023 On burst completion the FSM SHALL return to IDLE, giving a single idle bubble between back-to-back bursts.
REQ-024 Outside valid cycles:
- result_o, idx_o, sbox_sub_o = 0.
- valid_o, gnt_o = 0.
REQ-025 Counter SHALL be 4 bits; length 15 ends at idx 15 without wrapping into a 17th byte.

Reset
REQ-026 On rst_i high at a clock edge, the following SHALL hold the next cycle:
- FSM = IDLE; pointer, counter and latches = 0.
- All outputs = 0.
REQ-027 Reset mid-burst SHALL abort the burst with no further valid_o and no done_o.

Configuration
REQ-028 Macro AES128_SBOX_ARB_REG_EN: when defined, sbox_sub_i is registered before result_o.
REQ-029 Effect of the registered path:
- result_o, valid_o and idx_o lag sbox_sub_o by one cycle.
- After the last BURST cycle the FSM passes through DRAIN for one cycle, with gnt_o still held, to emit the final result.
- done_o pulses the cycle after DRAIN.
REQ-030 When the macro is undefined:
- Result path is combinational, per REQ-021.
- DRAIN state is absent.

Verification
REQ-031 Reset, then req_i=01, len_i[0]=15, S-box model = identity XOR 0x63 -> 16 valids on bit0, idx_o 0..15, result_o=data^0x63, done_o=01 one cycle after idx 15.
REQ-032 Request arrival:
- req_i=11 in the same cycle after reset -> requester 0 served first.
- Requester 1 (len_i[1]=3) then gets 4 valids after one idle cycle.
- done_o sequence is 01 then 10.
REQ-033 Requester 0 drops req_i and changes len_i during burst 3 of 8 -> all 8 bytes still delivered; gnt_o stays 01 throughout.
REQ-034 rst_i asserted at idx 5 of a 16-byte burst -> next cycle busy_o=0, all outputs 0, no done_o; the new request is then served from idx 0.
REQ-035 With AES128_SBOX_ARB_REG_EN, len=0 -> one valid, one cycle after sbox_sub_o shows the byte; DRAIN observed; done_o one cycle after that valid.
